// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared state encoding and default geometry for the frame buffer swap controller
package fb_pkg;

  typedef enum logic [1:0] {
    DRAW    = 2'd0,
    WAIT_VS = 2'd1,
    CLEAR   = 2'd2,
    ACK     = 2'd3
  } fb_state_e;

  localparam int          FB_DEPTH     = 76800;
  localparam int          FB_ADDR_W    = 17;
  localparam logic [31:0] FB_CLEAR_VAL = 32'h0000_0000;

endpackage

// File: rtl/frame_buffer_swap_ctrl.sv
// rtl/frame_buffer_swap_ctrl.sv - double-buffered frame RAM write steering with vsync-timed bank swap and clear
module frame_buffer_swap_ctrl
  import fb_pkg::*;
#(
  parameter int              DEPTH     = FB_DEPTH,
  parameter int              ADDR_W    = FB_ADDR_W,
  parameter int              DATA_W    = 32,
  parameter bit              CLEAR_EN  = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(FB_CLEAR_VAL)
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              bb_we,
  input  logic [31:0]       din,
  input  logic [31:0]       waddr,
  input  logic              done,
  input  logic              vsync,
  output logic              swap,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              front_sel,
  output logic              err,
  output logic [15:0]       frame_cnt
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  fb_state_e         state;
  logic              vs_q;
  logic [ADDR_W-1:0] clr_cnt;
  logic              addr_ok;
  logic              vs_rise;

  assign addr_ok = (waddr < 32'(DEPTH));
  assign vs_rise = vsync & ~vs_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= DRAW;
      vs_q      <= 1'b0;
      clr_cnt   <= '0;
      swap      <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      front_sel <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_q   <= vsync;
      mem_we <= 1'b0;

      // Writes are only accepted while drawing and in range; anything else is lost.
      if (bb_we && ((state != DRAW) || !addr_ok))
        err <= 1'b1;

      case (state)
        DRAW: begin
          if (bb_we && addr_ok) begin
            mem_we    <= 1'b1;
            mem_waddr <= {~front_sel, waddr[ADDR_W-1:0]};
            mem_wdata <= din[DATA_W-1:0];
          end
          if (done)
            state <= WAIT_VS;
        end

        WAIT_VS: begin
          if (vs_rise) begin
            front_sel <= ~front_sel;
            frame_cnt <= frame_cnt + 16'd1;
            clr_cnt   <= '0;
            state     <= CLEAR_EN ? CLEAR : ACK;
          end
        end

        // front_sel has already flipped, so ~front_sel is the bank just retired from display.
        CLEAR: begin
          mem_we    <= 1'b1;
          mem_waddr <= {~front_sel, clr_cnt};
          mem_wdata <= CLEAR_VAL;
          clr_cnt   <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST)
            state <= ACK;
        end

        ACK: begin
          if (!swap) begin
            swap <= 1'b1;
          end else if (!done) begin
            swap  <= 1'b0;
            state <= DRAW;
          end
        end

        default: state <= DRAW;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_swap_ctrl.sv
// tb/tb_frame_buffer_swap_ctrl.sv - scoreboard bench for frame_buffer_swap_ctrl
module tb_frame_buffer_swap_ctrl;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              bb_we, done, vsync;
  logic [31:0]       din, waddr;
  logic              swap, mem_we, front_sel, err;
  logic [ADDR_W:0]   mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [15:0]       frame_cnt;

  logic              bb_we2, done2, vsync2;
  logic [31:0]       din2, waddr2;
  logic              swap2, mem_we2, front_sel2, err2;
  logic [ADDR_W:0]   mem_waddr2;
  logic [DATA_W-1:0] mem_wdata2;
  logic [15:0]       frame_cnt2;

  int errors = 0;
  int checks = 0;
  logic [ADDR_W+DATA_W:0] sb[$];

  always #5 clk = ~clk;

  frame_buffer_swap_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_EN(1'b1)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .bb_we(bb_we), .din(din), .waddr(waddr),
    .done(done), .vsync(vsync), .swap(swap), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .front_sel(front_sel), .err(err), .frame_cnt(frame_cnt)
  );

  frame_buffer_swap_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_EN(1'b0)) dut2 (
    .clk_clk(clk), .reset_reset_n(rst_n), .bb_we(bb_we2), .din(din2), .waddr(waddr2),
    .done(done2), .vsync(vsync2), .swap(swap2), .mem_we(mem_we2), .mem_waddr(mem_waddr2),
    .mem_wdata(mem_wdata2), .front_sel(front_sel2), .err(err2), .frame_cnt(frame_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, required no write", mem_waddr, mem_wdata);
      end else begin
        logic [ADDR_W+DATA_W:0] e;
        e = sb.pop_front();
        chk("write_addr", 32'(mem_waddr), 32'(e[ADDR_W+DATA_W:DATA_W]));
        chk("write_data", mem_wdata, e[DATA_W-1:0]);
      end
    end
    if (mem_we2 === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL noclear_write: addr %h, required no write", mem_waddr2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bb_we = 1'b1; waddr = a; din = d;
    cyc();
    bb_we = 1'b0;
  endtask

  task automatic expect_wr(input logic bank, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    sb.push_back({bank, a, d});
  endtask

  task automatic wait_swap(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (swap === 1'b1) break;
    end
    chk(name, 32'(swap), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bb_we = 0; done = 0; vsync = 0; din = 0; waddr = 0;
    bb_we2 = 0; done2 = 0; vsync2 = 0; din2 = 0; waddr2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_waddr", 32'(mem_waddr), 0);
    chk("rst_front_sel", 32'(front_sel), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_swap", 32'(swap), 0);
    rst_n = 1'b1;
    cyc();

    // Basic writes into back bank 1, one out-of-range write sets sticky err.
    expect_wr(1'b1, 4'h3, 32'hA5);
    wr(3, 32'hA5);
    @(negedge clk);
    chk("err_after_good", 32'(err), 0);
    cyc();
    wr(16, 32'hBAD);
    @(negedge clk);
    chk("err_after_oob", 32'(err), 1);
    cyc();
    expect_wr(1'b1, 4'hF, 32'h1234);
    wr(15, 32'h1234);
    expect_wr(1'b1, 4'h0, 32'hDEADBEEF);
    wr(0, 32'hDEADBEEF);
    @(negedge clk);
    chk("err_sticky", 32'(err), 1);
    cyc();

    // done with a same-cycle write, vsync five cycles later, full clear of bank 0.
    expect_wr(1'b1, 4'h7, 32'h77);
    done = 1'b1;
    wr(7, 32'h77);
    repeat (5) cyc();
    for (int i = 0; i < DEPTH; i++) expect_wr(1'b0, 4'(i), 32'h0);
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    wait_swap("swap1_rise");
    chk("swap1_front_sel", 32'(front_sel), 1);
    chk("swap1_frame_cnt", 32'(frame_cnt), 1);
    chk("swap1_clears_done", 32'(sb.size()), 0);
    done = 1'b0;
    @(negedge clk); #1;
    chk("swap1_fall", 32'(swap), 0);
    cyc();
    expect_wr(1'b0, 4'h2, 32'h22);
    wr(2, 32'h22);
    cyc();

    // vsync rising together with done is not a swap edge.
    done = 1'b1; vsync = 1'b1;
    repeat (3) cyc();
    vsync = 1'b0;
    repeat (2) cyc();
    chk("coinc_frame_cnt", 32'(frame_cnt), 1);
    chk("coinc_front_sel", 32'(front_sel), 1);
    chk("coinc_swap", 32'(swap), 0);
    for (int i = 0; i < DEPTH; i++) expect_wr(1'b1, 4'(i), 32'h0);
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    wait_swap("swap2_rise");
    chk("swap2_front_sel", 32'(front_sel), 0);
    chk("swap2_frame_cnt", 32'(frame_cnt), 2);
    done = 1'b0;
    repeat (2) cyc();

    // Write outside DRAW is dropped; reset lands mid-clear.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rst2_err", 32'(err), 0);
    chk("rst2_frame_cnt", 32'(frame_cnt), 0);
    done = 1'b1;
    cyc();
    wr(1, 32'h11);
    @(negedge clk);
    chk("err_wait_vs_write", 32'(err), 1);
    cyc();
    for (int i = 0; i < 7; i++) expect_wr(1'b0, 4'(i), 32'h0);
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    chk("clear_partial_seen", 32'(sb.size()), 0);
    rst_n = 1'b0;
    #1;
    chk("midclr_mem_we", 32'(mem_we), 0);
    chk("midclr_mem_waddr", 32'(mem_waddr), 0);
    chk("midclr_front_sel", 32'(front_sel), 0);
    chk("midclr_frame_cnt", 32'(frame_cnt), 0);
    chk("midclr_err", 32'(err), 0);
    chk("midclr_swap", 32'(swap), 0);
    done = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (20) cyc();

    // No-clear variant: ACK straight after the edge.
    done2 = 1'b1;
    repeat (2) cyc();
    vsync2 = 1'b1;
    cyc();
    @(negedge clk);
    chk("noclr_swap_edge1", 32'(swap2), 0);
    vsync2 = 1'b0;
    @(negedge clk);
    chk("noclr_swap_edge2", 32'(swap2), 1);
    chk("noclr_front_sel", 32'(front_sel2), 1);
    chk("noclr_frame_cnt", 32'(frame_cnt2), 1);
    done2 = 1'b0;
    @(negedge clk);
    chk("noclr_swap_fall", 32'(swap2), 0);
    repeat (3) cyc();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
